// File: rtl/irq_ctl.sv
// irq_ctl: programmable interrupt controller (edge/level, mask, W1C pend).
// Optional IRQ_CTL_SWI_EN: STAT writes raise software interrupts.
module irq_ctl #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             p_reset_n,
  input  logic [15:0]      src,
  input  logic             io_sel,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [1:0]       io_addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] io_dout,
  output logic             irq,
  output logic [3:0]       ivec,
  input  logic             iack
);

  logic [15:0] r_src;
  logic [15:0] r_src_d;
  logic [15:0] r_pend;
  logic [15:0] r_en;
  logic [15:0] r_mode;
  logic [15:0] r_dout;
  logic [3:0]  r_ivec;
  logic        r_irq;

  logic        w_wr;
  logic        w_rd;
  logic        w_ack;
  logic [15:0] w_ack_mask;
  logic [15:0] w_pclr;
  logic [15:0] w_swi;
  logic [15:0] w_rise;
  logic [15:0] w_edge_nxt;
  logic [15:0] w_pend_nxt;
  logic [15:0] w_active;
  logic [15:0] w_rdata;
  logic [3:0]  w_vec;
  logic        w_unused;

  assign w_wr = io_sel & io_wr;
  assign w_rd = io_sel & io_rd;

  // an iack with nothing presented is a no-op
  assign w_ack = iack & (r_ivec != 4'd0);
  assign w_ack_mask = w_ack ? (16'd1 << r_ivec) : 16'd0;
  assign w_pclr = (w_wr && io_addr == 2'd0) ? din[15:0] : 16'd0;

`ifdef IRQ_CTL_SWI_EN
  assign w_swi = (w_wr && io_addr == 2'd3) ?
                 {din[15:1], 1'b0} : 16'd0;
`else
  assign w_swi = 16'd0;
`endif

  // set beats clear so a new edge during iack is never lost
  assign w_rise     = r_src & ~r_src_d;
  assign w_edge_nxt = w_rise | (r_pend & ~(w_ack_mask | w_pclr));
  assign w_pend_nxt = ((r_mode & r_src)
                    | (~r_mode & w_edge_nxt)
                    | w_swi) & 16'hFFFE;

  assign w_active = r_pend & r_en & {16{r_en[0]}} & 16'hFFFE;

  always_comb begin
    w_vec = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (w_active[i]) w_vec = i[3:0];
    end
  end

  always_comb begin
    w_rdata = 16'd0;
    unique case (io_addr)
      2'd0: w_rdata = r_pend;
      2'd1: w_rdata = r_en;
      2'd2: w_rdata = r_mode;
      2'd3: w_rdata = {12'd0, r_ivec};
      default: w_rdata = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      r_src   <= '0;
      r_src_d <= '0;
      r_pend  <= '0;
      r_en    <= '0;
      r_mode  <= '0;
      r_dout  <= '0;
      r_ivec  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_src   <= src;
      r_src_d <= r_src;
      r_pend  <= w_pend_nxt;
      if (w_wr && io_addr == 2'd1) r_en   <= din[15:0];
      if (w_wr && io_addr == 2'd2) r_mode <= din[15:0];
      if (w_rd) r_dout <= w_rdata;
      // hide the serviced vector for one cycle after iack
      r_ivec <= w_ack ? 4'd0 : w_vec;
      r_irq  <= !w_ack && (w_vec != 4'd0);
    end
  end

  assign io_dout  = WIDTH'(r_dout);
  assign irq      = r_irq;
  assign ivec     = r_ivec;
  assign w_unused = ^din;

endmodule
